csr_master: RTL and testbench
=============================

CSR_MASTER -- requirements
Module: csr_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles spent waiting on acknowledge or read data before abort (range 1..65535).
REQ-002 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  reset; the block has one clock, and reset is synchronous and active-high.
REQ-004 SHALL have cmd_valid  input  1  client command present.
REQ-005 SHALL have cmd_read_not_write, cmd_select, cmd_address, cmd_data  input  1/16/16/32  command fields, sampled only when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have cmd_ready  output  1  block can accept a command this cycle.
REQ-007 SHALL have resp_valid  output  1  single-cycle completion pulse.
REQ-008 SHALL have resp_data, resp_error, resp_timeout  output  32/1/1  completion read data, error flag and timeout flag.
REQ-009 SHALL have csr_request__valid, csr_request__read_not_write, csr_request__select, csr_request__address, csr_request__data  output  1/1/16/16/32  CSR request bus.
REQ-010 SHALL have csr_response__acknowledge, csr_response__read_data_valid, csr_response__read_data_error, csr_response__read_data  input  1/1/1/32  CSR response bus.
REQ-011 SHALL have spurious_count  output  8  saturating count of response events seen with no transaction outstanding.

Function
REQ-012 SHALL implement states IDLE, REQUEST, WAIT_DATA, RESPOND; cmd_ready = 1 only in IDLE.
REQ-013 IDLE: on cmd_valid, SHALL register all command fields and enter REQUEST; csr_request__valid goes high on the next cycle (1-cycle latency).
REQ-014 REQUEST: csr_request__valid and all request fields SHALL stay constant until acknowledge is sampled high.
REQ-015 REQUEST with acknowledge high, write: SHALL enter RESPOND with resp_data=0, resp_error=0; csr_request__valid low from the next cycle.
REQ-016 REQUEST with acknowledge high, read: if read_data_valid is high in the same cycle, SHALL capture the data and enter RESPOND; otherwise enter WAIT_DATA. csr_request__valid drops in both cases.
REQ-017 WAIT_DATA with read_data_valid high: SHALL capture read_data into resp_data and read_data_error into resp_error, then enter RESPOND.
REQ-018 RESPOND: SHALL assert resp_valid for exactly one cycle, then return to IDLE; the earliest next command is accepted in that IDLE cycle.
REQ-019 SHALL run a 16-bit wait counter, cleared on entry to REQUEST and to WAIT_DATA and incremented each cycle in those states.
REQ-020 Timeout: if the counter reaches TIMEOUT with no acknowledge (REQUEST) or no read_data_valid (WAIT_DATA), SHALL drop csr_request__valid and enter RESPOND with resp_error=1, resp_timeout=1, resp_data=0.
REQ-021 An acknowledge or read_data_valid arriving in the same cycle the counter reaches TIMEOUT SHALL win over the timeout.
REQ-022 acknowledge or read_data_valid seen in IDLE or RESPOND, or read_data_valid seen in REQUEST before acknowledge, SHALL be ignored for data purposes and SHALL increment spurious_count, which saturates at 255.
REQ-023 resp_timeout SHALL be 0 on every non-timeout completion; resp_error on writes SHALL be 0 unless timed out.

Reset
REQ-024 Reset high SHALL, at the next edge and regardless of state, force IDLE, the wait counter to 0 and spurious_count to 0, and drive csr_request__valid=0, resp_valid=0, resp_error=0, resp_timeout=0, resp_data=0 and all csr_request fields to 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction with no resp_valid pulse; cmd_ready is 1 on the first cycle after reset deasserts.

Verification
REQ-026 Write select=0x0001, addr=0x0010, data=0xDEADBEEF; target acks after 3 cycles -> request fields stable for 4 cycles, valid drops the cycle after ack, then resp_valid pulse with error=0.
REQ-027 Read; ack and read_data_valid in the same cycle with data 0x12345678 -> resp_data=0x12345678, error=0, no WAIT_DATA cycle.
REQ-028 Read; ack, then read_data_valid 5 cycles later with read_data_error=1 -> resp_error=1, resp_timeout=0.
REQ-029 TIMEOUT=4, no ack -> valid high exactly 4 cycles then low, resp_valid with error=1, timeout=1, data=0; a variant with ack on the 4th cycle -> normal completion.
REQ-030 Three unsolicited acknowledges in IDLE -> spurious_count=3; 300 of them -> 255.
REQ-031 Reset in WAIT_DATA -> no resp_valid, csr_request__valid=0, cmd_ready=1 after release; the next read completes normally.

Source files
------------

// File: rtl/csr_master_if.sv
// Client command/response and CSR request/response signals for csr_master.
// The master modport is the csr_master view; slave is the environment view.
interface csr_master_if;
    logic        cmd_valid;
    logic        cmd_read_not_write;
    logic [15:0] cmd_select;
    logic [15:0] cmd_address;
    logic [31:0] cmd_data;
    logic        cmd_ready;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        resp_timeout;

    logic        csr_request__valid;
    logic        csr_request__read_not_write;
    logic [15:0] csr_request__select;
    logic [15:0] csr_request__address;
    logic [31:0] csr_request__data;

    logic        csr_response__acknowledge;
    logic        csr_response__read_data_valid;
    logic        csr_response__read_data_error;
    logic [31:0] csr_response__read_data;

    logic [7:0]  spurious_count;

    modport master (
        input  cmd_valid, cmd_read_not_write, cmd_select,
        input  cmd_address, cmd_data,
        output cmd_ready,
        output resp_valid, resp_data, resp_error, resp_timeout,
        output csr_request__valid, csr_request__read_not_write,
        output csr_request__select, csr_request__address,
        output csr_request__data,
        input  csr_response__acknowledge,
        input  csr_response__read_data_valid,
        input  csr_response__read_data_error,
        input  csr_response__read_data,
        output spurious_count
    );

    modport slave (
        output cmd_valid, cmd_read_not_write, cmd_select,
        output cmd_address, cmd_data,
        input  cmd_ready,
        input  resp_valid, resp_data, resp_error, resp_timeout,
        input  csr_request__valid, csr_request__read_not_write,
        input  csr_request__select, csr_request__address,
        input  csr_request__data,
        output csr_response__acknowledge,
        output csr_response__read_data_valid,
        output csr_response__read_data_error,
        output csr_response__read_data,
        input  spurious_count
    );
endinterface

// File: rtl/csr_master.sv
// Single-outstanding CSR bus master: one client command becomes one CSR
// transaction with acknowledge/read-data handling and a wait timeout.
module csr_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    csr_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        RESPOND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [16:0] cnt_inc;
    logic        cnt_hit;
    logic        load_cmd;
    logic        cnt_clr;
    logic        done_wr;
    logic        done_rd;
    logic        done_to;
    logic        spur_inc;

    logic        req_rnw;
    logic [15:0] req_sel;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_to;
    logic [7:0]  spur_cnt;

    logic ack;
    logic rdv;

    assign ack = bus.csr_response__acknowledge;
    assign rdv = bus.csr_response__read_data_valid;

    // Timeout fires in the cycle whose increment would reach TIMEOUT.
    assign cnt_inc = {1'b0, wait_cnt} + 17'd1;
    assign cnt_hit = (cnt_inc == 17'(TIMEOUT));

    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        cnt_clr    = 1'b0;
        done_wr    = 1'b0;
        done_rd    = 1'b0;
        done_to    = 1'b0;
        spur_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                spur_inc = ack | rdv;
                if (bus.cmd_valid) begin
                    load_cmd   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (ack) begin
                    if (!req_rnw) begin
                        done_wr    = 1'b1;
                        state_next = RESPOND;
                    end else if (rdv) begin
                        done_rd    = 1'b1;
                        state_next = RESPOND;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = WAIT_DATA;
                    end
                end else begin
                    spur_inc = rdv;
                    if (cnt_hit) begin
                        done_to    = 1'b1;
                        state_next = RESPOND;
                    end
                end
            end
            WAIT_DATA: begin
                if (rdv) begin
                    done_rd    = 1'b1;
                    state_next = RESPOND;
                end else if (cnt_hit) begin
                    done_to    = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                spur_inc   = ack | rdv;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
            req_rnw  <= 1'b0;
            req_sel  <= 16'd0;
            req_addr <= 16'd0;
            req_data <= 32'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
            rsp_to   <= 1'b0;
            spur_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (load_cmd) begin
                req_rnw  <= bus.cmd_read_not_write;
                req_sel  <= bus.cmd_select;
                req_addr <= bus.cmd_address;
                req_data <= bus.cmd_data;
            end
            if (cnt_clr) begin
                wait_cnt <= 16'd0;
            end else if (state == REQUEST || state == WAIT_DATA) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (done_wr) begin
                rsp_data <= 32'd0;
                rsp_err  <= 1'b0;
                rsp_to   <= 1'b0;
            end else if (done_rd) begin
                rsp_data <= bus.csr_response__read_data;
                rsp_err  <= bus.csr_response__read_data_error;
                rsp_to   <= 1'b0;
            end else if (done_to) begin
                rsp_data <= 32'd0;
                rsp_err  <= 1'b1;
                rsp_to   <= 1'b1;
            end
            if (spur_inc && spur_cnt != 8'hFF) begin
                spur_cnt <= spur_cnt + 8'd1;
            end
        end
    end

    assign bus.cmd_ready                   = (state == IDLE);
    assign bus.resp_valid                  = (state == RESPOND);
    assign bus.resp_data                   = rsp_data;
    assign bus.resp_error                  = rsp_err;
    assign bus.resp_timeout                = rsp_to;
    assign bus.csr_request__valid          = (state == REQUEST);
    assign bus.csr_request__read_not_write = req_rnw;
    assign bus.csr_request__select         = req_sel;
    assign bus.csr_request__address        = req_addr;
    assign bus.csr_request__data           = req_data;
    assign bus.spurious_count              = spur_cnt;

endmodule

// File: tb/tb_csr_master.sv
// Scoreboard bench for csr_master: default-TIMEOUT instance (a) and a
// TIMEOUT=4 instance (b), both on one clock.
module tb_csr_master;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        t;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    rsp_t qa[$];
    rsp_t qb[$];

    always #5 clk = ~clk;

    csr_master_if a();
    csr_master_if b();

    csr_master dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a.master)
    );

    csr_master #(.TIMEOUT(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b.master)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] d, input logic e,
                                input logic t);
        rsp_t r;
        r.d = d;
        r.e = e;
        r.t = t;
        return r;
    endfunction

    // Monitors: pop the expected response on every completion pulse.
    always @(negedge clk) begin
        if (a.resp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_resp act=%h exp=none",
                         a.resp_data);
            end else begin
                rsp_t e;
                e = qa.pop_front();
                chk("a_resp_data", a.resp_data, e.d);
                chk("a_resp_error", a.resp_error, e.e);
                chk("a_resp_timeout", a.resp_timeout, e.t);
            end
        end
    end

    always @(negedge clk) begin
        if (b.resp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_resp act=%h exp=none",
                         b.resp_data);
            end else begin
                rsp_t e;
                e = qb.pop_front();
                chk("b_resp_data", b.resp_data, e.d);
                chk("b_resp_error", b.resp_error, e.e);
                chk("b_resp_timeout", b.resp_timeout, e.t);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first REQUEST cycle.
    task automatic issue(input bit on_b, input bit rnw, input logic [15:0] s,
                         input logic [15:0] ad, input logic [31:0] d);
        int n = 0;
        while ((on_b ? b.cmd_ready : a.cmd_ready) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL issue_ready_wait act=0 exp=1");
        end
        if (on_b) begin
            b.cmd_read_not_write = rnw;
            b.cmd_select = s;
            b.cmd_address = ad;
            b.cmd_data = d;
            b.cmd_valid = 1'b1;
        end else begin
            a.cmd_read_not_write = rnw;
            a.cmd_select = s;
            a.cmd_address = ad;
            a.cmd_data = d;
            a.cmd_valid = 1'b1;
        end
        @(negedge clk);
        a.cmd_valid = 1'b0;
        b.cmd_valid = 1'b0;
    endtask

    task automatic idle_bus(input bit on_b);
        if (on_b) begin
            b.csr_response__acknowledge = 1'b0;
            b.csr_response__read_data_valid = 1'b0;
            b.csr_response__read_data_error = 1'b0;
            b.csr_response__read_data = 32'd0;
        end else begin
            a.csr_response__acknowledge = 1'b0;
            a.csr_response__read_data_valid = 1'b0;
            a.csr_response__read_data_error = 1'b0;
            a.csr_response__read_data = 32'd0;
        end
    endtask

    initial begin
        int n;
        a.cmd_valid = 1'b0;
        a.cmd_read_not_write = 1'b0;
        a.cmd_select = 16'd0;
        a.cmd_address = 16'd0;
        a.cmd_data = 32'd0;
        b.cmd_valid = 1'b0;
        b.cmd_read_not_write = 1'b0;
        b.cmd_select = 16'd0;
        b.cmd_address = 16'd0;
        b.cmd_data = 32'd0;
        idle_bus(1'b0);
        idle_bus(1'b1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_cmd_ready", a.cmd_ready, 1);
        chk("rst_req_valid", a.csr_request__valid, 0);
        chk("rst_resp_valid", a.resp_valid, 0);
        chk("rst_resp_data", a.resp_data, 0);
        chk("rst_req_select", a.csr_request__select, 0);
        chk("rst_req_data", a.csr_request__data, 0);
        chk("rst_spurious", a.spurious_count, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // Write, ack in the 4th request cycle.
        qa.push_back(mk(32'd0, 1'b0, 1'b0));
        issue(1'b0, 1'b0, 16'h0001, 16'h0010, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            chk("wr_req_valid", a.csr_request__valid, 1);
            chk("wr_req_rnw", a.csr_request__read_not_write, 0);
            chk("wr_req_select", a.csr_request__select, 16'h0001);
            chk("wr_req_addr", a.csr_request__address, 16'h0010);
            chk("wr_req_data", a.csr_request__data, 32'hDEADBEEF);
            chk("wr_cmd_ready_busy", a.cmd_ready, 0);
            if (i == 3) a.csr_response__acknowledge = 1'b1;
            @(negedge clk);
        end
        idle_bus(1'b0);
        chk("wr_valid_dropped", a.csr_request__valid, 0);
        chk("wr_resp_pulse", a.resp_valid, 1);
        @(negedge clk);
        chk("wr_resp_single", a.resp_valid, 0);
        chk("wr_ready_back", a.cmd_ready, 1);

        // Read with ack and data together: no WAIT_DATA cycle.
        qa.push_back(mk(32'h12345678, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 16'h0002, 16'h0020, 32'h0);
        chk("rd0_req_rnw", a.csr_request__read_not_write, 1);
        a.csr_response__acknowledge = 1'b1;
        a.csr_response__read_data_valid = 1'b1;
        a.csr_response__read_data = 32'h12345678;
        @(negedge clk);
        idle_bus(1'b0);
        chk("rd0_no_wait", a.resp_valid, 1);
        @(negedge clk);

        // Read, data 5 cycles after ack, with error.
        qa.push_back(mk(32'hCAFEF00D, 1'b1, 1'b0));
        issue(1'b0, 1'b1, 16'h0003, 16'h0030, 32'h0);
        a.csr_response__acknowledge = 1'b1;
        @(negedge clk);
        idle_bus(1'b0);
        chk("rd1_valid_dropped", a.csr_request__valid, 0);
        repeat (4) @(negedge clk);
        chk("rd1_still_waiting", a.resp_valid, 0);
        a.csr_response__read_data_valid = 1'b1;
        a.csr_response__read_data_error = 1'b1;
        a.csr_response__read_data = 32'hCAFEF00D;
        @(negedge clk);
        idle_bus(1'b0);
        chk("rd1_resp_pulse", a.resp_valid, 1);
        @(negedge clk);

        // Unsolicited acknowledges in IDLE.
        for (int i = 0; i < 3; i++) begin
            a.csr_response__acknowledge = 1'b1;
            @(negedge clk);
            a.csr_response__acknowledge = 1'b0;
            @(negedge clk);
        end
        chk("spur_three", a.spurious_count, 3);
        for (int i = 0; i < 297; i++) begin
            a.csr_response__acknowledge = 1'b1;
            @(negedge clk);
            a.csr_response__acknowledge = 1'b0;
            @(negedge clk);
        end
        chk("spur_saturate", a.spurious_count, 255);

        // Reset during WAIT_DATA abandons the read.
        issue(1'b0, 1'b1, 16'h0004, 16'h0040, 32'h0);
        a.csr_response__acknowledge = 1'b1;
        @(negedge clk);
        idle_bus(1'b0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("rstw_req_valid", a.csr_request__valid, 0);
        chk("rstw_resp_valid", a.resp_valid, 0);
        chk("rstw_spurious", a.spurious_count, 0);
        @(negedge clk);
        chk("rstw_ready", a.cmd_ready, 1);
        qa.push_back(mk(32'hA5A50001, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 16'h0005, 16'h0050, 32'h0);
        a.csr_response__acknowledge = 1'b1;
        a.csr_response__read_data_valid = 1'b1;
        a.csr_response__read_data = 32'hA5A50001;
        @(negedge clk);
        idle_bus(1'b0);
        chk("rstw_next_read", a.resp_valid, 1);
        @(negedge clk);

        // TIMEOUT=4 instance: request timeout with no ack.
        qb.push_back(mk(32'd0, 1'b1, 1'b1));
        issue(1'b1, 1'b0, 16'h0100, 16'h0200, 32'h11112222);
        n = 0;
        while (b.csr_request__valid === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_valid_cycles", n, 4);
        chk("to_resp_pulse", b.resp_valid, 1);
        @(negedge clk);

        // Ack in the 4th cycle beats the timeout.
        qb.push_back(mk(32'd0, 1'b0, 1'b0));
        issue(1'b1, 1'b0, 16'h0101, 16'h0201, 32'h33334444);
        repeat (3) @(negedge clk);
        chk("to_ack_still_valid", b.csr_request__valid, 1);
        b.csr_response__acknowledge = 1'b1;
        @(negedge clk);
        idle_bus(1'b1);
        chk("to_ack_resp", b.resp_valid, 1);
        @(negedge clk);

        // Read timing out in WAIT_DATA.
        qb.push_back(mk(32'd0, 1'b1, 1'b1));
        issue(1'b1, 1'b1, 16'h0102, 16'h0202, 32'h0);
        b.csr_response__acknowledge = 1'b1;
        @(negedge clk);
        idle_bus(1'b1);
        n = 0;
        while (b.resp_valid !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_wait_cycles", n, 4);
        @(negedge clk);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
